// File: rtl/irq_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller_pkg
// Description : Shared register map constants and helpers for irq_controller.
//               The SWSET offset is only decoded when IRQC_SWINT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_controller_pkg;

    typedef logic [7:0] ofs_t;

    localparam ofs_t c_OFS_RAW     = 8'h00;
    localparam ofs_t c_OFS_ENABLE  = 8'h04;
    localparam ofs_t c_OFS_PENDING = 8'h08;
    localparam ofs_t c_OFS_EDGE    = 8'h0C;
    localparam ofs_t c_OFS_VECTOR  = 8'h10;
    localparam ofs_t c_OFS_SWSET   = 8'h14;

    // Short aliases used throughout the design
    localparam ofs_t OFS_RAW     = c_OFS_RAW;
    localparam ofs_t OFS_ENABLE  = c_OFS_ENABLE;
    localparam ofs_t OFS_PENDING = c_OFS_PENDING;
    localparam ofs_t OFS_EDGE    = c_OFS_EDGE;
    localparam ofs_t OFS_VECTOR  = c_OFS_VECTOR;
    localparam ofs_t OFS_SWSET   = c_OFS_SWSET;

    localparam int VECTOR_VALID_BIT = 31;

    // Expand the four byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Per-source synchroniser chain plus edge/level event detector.
//               o_sync is the synchronised level; o_event is the rising edge
//               (i_edge=1) or the level itself (i_edge=0).
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_src,
    input  logic i_edge,
    output logic o_sync,
    output logic o_event
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchroniser shift chain and previous-level tracker (prev updates every cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync  = r_sync[SYNC_STAGES-1];
    assign o_event = i_edge ? (o_sync & ~r_prev) : o_sync;

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Memory-mapped interrupt controller. Synchronises sources,
//               latches edge/level events into PENDING, masks with ENABLE,
//               and drives a registered active-low nIRQ. Optional software
//               set register (offset 0x14) is built when IRQC_SWINT_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int          NUM_SRC     = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        memaddr,
    input  logic               memwrite,
    input  logic [3:0]         be,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               sel,
    output logic               nIRQ
);

    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_edge;
    logic               r_nirq;

    logic [NUM_SRC-1:0] w_sync;
    logic [NUM_SRC-1:0] w_event;
    logic [7:0]         w_ofs;
    logic               w_wr;
    logic [31:0]        w_wbits;
    logic [NUM_SRC-1:0] w_wmask;
    logic [NUM_SRC-1:0] w_wdata;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_en_next;
    logic [NUM_SRC-1:0] w_pend_next;
    logic [NUM_SRC-1:0] w_edge_next;
    logic [NUM_SRC-1:0] w_active;
    logic               w_any;
    logic [4:0]         w_vec_idx;
    logic               w_unused_wbits;

    // One synchroniser/detector per source
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge (
                .clk     (clk),
                .rst     (reset),
                .i_src   (irq_src[gi]),
                .i_edge  (r_edge[gi]),
                .o_sync  (w_sync[gi]),
                .o_event (w_event[gi])
            );
        end
    endgenerate

    // Bus decode: only the upper address bits select the block
    assign sel            = (memaddr[31:8] == BASE_ADDR[31:8]);
    assign w_ofs          = memaddr[7:0];
    assign w_wr           = sel & memwrite;
    assign w_wbits        = writedata & byte_mask(be);
    assign w_wmask        = byte_mask(be) >> 0;
    assign w_wdata        = w_wbits[NUM_SRC-1:0];
    assign w_unused_wbits = ^w_wbits;

    // Next-state for the software-visible registers; set always beats W1C
    always_comb begin
        w_en_next   = r_enable;
        w_edge_next = r_edge;
        w_clr       = '0;
        if (w_wr && (w_ofs == OFS_ENABLE)) begin
            w_en_next = (r_enable & ~w_wmask) | w_wdata;
        end
        if (w_wr && (w_ofs == OFS_EDGE)) begin
            w_edge_next = (r_edge & ~w_wmask) | w_wdata;
        end
        if (w_wr && (w_ofs == OFS_PENDING)) begin
            w_clr = w_wdata;
        end
`ifdef IRQC_SWINT_EN
        if (w_wr && (w_ofs == OFS_SWSET)) begin
            w_pend_next = w_event | w_wdata | (r_pending & ~w_clr);
        end else begin
            w_pend_next = w_event | (r_pending & ~w_clr);
        end
`else
        w_pend_next = w_event | (r_pending & ~w_clr);
`endif
    end

    // Register update, including the registered active-low request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable  <= '0;
            r_pending <= '0;
            r_edge    <= '0;
            r_nirq    <= 1'b1;
        end else begin
            r_enable  <= w_en_next;
            r_pending <= w_pend_next;
            r_edge    <= w_edge_next;
            r_nirq    <= ~|(w_pend_next & w_en_next);
        end
    end

    assign nIRQ     = r_nirq;
    assign w_active = r_pending & r_enable;
    assign w_any    = |w_active;

    // Priority encoder: lowest active index wins
    always_comb begin
        w_vec_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec_idx = 5'(i);
            end
        end
    end

    // Read mux; unselected or unmapped accesses return zero
    always_comb begin
        readdata = '0;
        if (sel) begin
            case (w_ofs)
                OFS_RAW:     readdata[NUM_SRC-1:0] = w_sync;
                OFS_ENABLE:  readdata[NUM_SRC-1:0] = r_enable;
                OFS_PENDING: readdata[NUM_SRC-1:0] = r_pending;
                OFS_EDGE:    readdata[NUM_SRC-1:0] = r_edge;
                OFS_VECTOR: begin
                    readdata[VECTOR_VALID_BIT] = w_any;
                    readdata[4:0]              = w_vec_idx;
                end
                default:     readdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller (8 sources,
//               2 sync stages). Exercises SWSET when IRQC_SWINT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    localparam logic [31:0] c_BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic [31:0] memaddr;
    logic        memwrite;
    logic [3:0]  be;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sel;
    logic        nIRQ;

    int n_checks = 0;
    int n_fail   = 0;

    irq_controller #(
        .NUM_SRC     (8),
        .BASE_ADDR   (c_BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .memaddr   (memaddr),
        .memwrite  (memwrite),
        .be        (be),
        .writedata (writedata),
        .readdata  (readdata),
        .sel       (sel),
        .nIRQ      (nIRQ)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [31:0] data, input logic [3:0] ben);
        memaddr   = c_BASE | {24'h0, ofs};
        memwrite  = 1'b1;
        writedata = data;
        be        = ben;
        tick(1);
        memwrite  = 1'b0;
        writedata = '0;
        be        = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] ofs, input logic [31:0] exp);
        memaddr  = c_BASE | {24'h0, ofs};
        memwrite = 1'b0;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b1; irq_src = '0; memaddr = '0; memwrite = 1'b0; be = '0; writedata = '0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        chk("rst_nirq", {31'h0, nIRQ}, 32'h1);
        rd_chk("rst_raw",  8'h00, 32'h0);
        rd_chk("rst_en",   8'h04, 32'h0);
        rd_chk("rst_pend", 8'h08, 32'h0);
        rd_chk("rst_edge", 8'h0C, 32'h0);
        rd_chk("rst_vec",  8'h10, 32'h0);
        rd_chk("rst_sw",   8'h14, 32'h0);
        chk("sel_hit", {31'h0, sel}, 32'h1);
        memaddr = 32'h0000_0004; #1;
        chk("sel_miss", {31'h0, sel}, 32'h0);
        chk("rd_miss", readdata, 32'h0);

        // Byte enables and unimplemented high bits
        wr(8'h04, 32'h0000_00FF, 4'b0010);
        rd_chk("be_mask", 8'h04, 32'h0);
        wr(8'h04, 32'hFFFF_FFFF, 4'hF);
        rd_chk("en_width", 8'h04, 32'h0000_00FF);

        // Edge mode: one-cycle pulse on source 0
        wr(8'h0C, 32'h01, 4'hF);
        wr(8'h04, 32'h01, 4'hF);
        irq_src = 8'h01;
        tick(1);
        irq_src = 8'h00;
        chk("edge_lat1", {31'h0, nIRQ}, 32'h1);
        tick(1);
        chk("edge_lat2", {31'h0, nIRQ}, 32'h1);
        tick(1);
        chk("edge_lat3", {31'h0, nIRQ}, 32'h0);
        rd_chk("edge_vec",  8'h10, 32'h8000_0000);
        rd_chk("edge_pend", 8'h08, 32'h01);
        wr(8'h08, 32'h01, 4'hF);
        chk("edge_w1c_nirq", {31'h0, nIRQ}, 32'h1);
        rd_chk("edge_w1c_pend", 8'h08, 32'h0);

        // Level mode on source 2
        wr(8'h0C, 32'h00, 4'hF);
        wr(8'h04, 32'h04, 4'hF);
        irq_src = 8'h04;
        tick(3);
        rd_chk("lvl_raw", 8'h00, 32'h04);
        chk("lvl_nirq", {31'h0, nIRQ}, 32'h0);
        wr(8'h08, 32'h04, 4'hF);
        rd_chk("lvl_w1c_held", 8'h08, 32'h04);
        tick(2);
        chk("lvl_nirq_held", {31'h0, nIRQ}, 32'h0);
        irq_src = 8'h00;
        tick(3);
        rd_chk("lvl_latched", 8'h08, 32'h04);
        wr(8'h08, 32'h04, 4'hF);
        rd_chk("lvl_clr_pend", 8'h08, 32'h0);
        chk("lvl_clr_nirq", {31'h0, nIRQ}, 32'h1);

        // Priority and masking
        wr(8'h04, 32'h20, 4'hF);
        irq_src = 8'h28;
        tick(1);
        irq_src = 8'h00;
        tick(4);
        rd_chk("pri_pend", 8'h08, 32'h28);
        rd_chk("pri_vec5", 8'h10, 32'h8000_0005);
        chk("pri_nirq", {31'h0, nIRQ}, 32'h0);
        wr(8'h04, 32'h28, 4'hF);
        rd_chk("pri_vec3", 8'h10, 32'h8000_0003);
        wr(8'h04, 32'h00, 4'hF);
        chk("mask_nirq", {31'h0, nIRQ}, 32'h1);
        rd_chk("mask_pend", 8'h08, 32'h28);
        rd_chk("mask_vec", 8'h10, 32'h0);
        wr(8'h04, 32'h20, 4'hF);
        chk("reenable_nirq", {31'h0, nIRQ}, 32'h0);
        wr(8'h08, 32'h28, 4'hF);
        rd_chk("pri_clr", 8'h08, 32'h0);
        chk("pri_clr_nirq", {31'h0, nIRQ}, 32'h1);

        // Collision: W1C on bit 1 in the cycle its new edge event is detected
        wr(8'h0C, 32'h02, 4'hF);
        wr(8'h04, 32'h02, 4'hF);
        irq_src = 8'h02; tick(1); irq_src = 8'h00;
        tick(3);
        rd_chk("col_pre", 8'h08, 32'h02);
        irq_src = 8'h02; tick(1); irq_src = 8'h00;
        tick(1);
        wr(8'h08, 32'h02, 4'hF);
        rd_chk("col_set_wins", 8'h08, 32'h02);
        chk("col_nirq", {31'h0, nIRQ}, 32'h0);
        wr(8'h08, 32'h02, 4'hF);
        rd_chk("col_clr", 8'h08, 32'h0);

        // Switching to edge mode while line is high creates no event
        wr(8'h0C, 32'h00, 4'hF);
        wr(8'h04, 32'h40, 4'hF);
        irq_src = 8'h40;
        tick(3);
        rd_chk("sw_edge_pre", 8'h08, 32'h40);
        wr(8'h0C, 32'h40, 4'hF);
        rd_chk("edge_wr_keeps_pend", 8'h08, 32'h40);
        wr(8'h08, 32'h40, 4'hF);
        tick(2);
        rd_chk("edge_no_event", 8'h08, 32'h0);
        chk("edge_no_event_nirq", {31'h0, nIRQ}, 32'h1);
        irq_src = 8'h00;
        tick(3);

`ifdef IRQC_SWINT_EN
        wr(8'h04, 32'h80, 4'hF);
        wr(8'h14, 32'h80, 4'hF);
        rd_chk("swset_pend", 8'h08, 32'h80);
        chk("swset_nirq", {31'h0, nIRQ}, 32'h0);
        rd_chk("swset_rd0", 8'h14, 32'h0);
        rd_chk("swset_vec", 8'h10, 32'h8000_0007);
`else
        wr(8'h04, 32'h80, 4'hF);
        wr(8'h14, 32'h80, 4'hF);
        rd_chk("unmapped_pend", 8'h08, 32'h0);
        chk("unmapped_nirq", {31'h0, nIRQ}, 32'h1);
        rd_chk("unmapped_rd0", 8'h14, 32'h0);
`endif

        // Mid-operation reset discards pending state
        wr(8'h0C, 32'h00, 4'hF);
        wr(8'h04, 32'h01, 4'hF);
        irq_src = 8'h01;
        tick(3);
        chk("pre_rst_nirq", {31'h0, nIRQ}, 32'h0);
        reset = 1'b1;
        tick(1);
        chk("midrst_nirq", {31'h0, nIRQ}, 32'h1);
        irq_src = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(1);
        rd_chk("midrst_pend", 8'h08, 32'h0);
        rd_chk("midrst_en",   8'h04, 32'h0);
        rd_chk("midrst_raw",  8'h00, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
